alu_op_arbiter: RTL

// - Shares one serial-interface ALU between NREQ requesters using round-robin arbitration.
// - Serialises the granted operation (data words, then command word) onto the ALU input line.
// - Deserialises the 3-word response (status, data-hi, data-lo) and returns it to the owning requester.
// - Sits between the test/host sequencers and the ALU DUT; one operation in flight at a time.

---
 rtl/alu_op_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter that serialises one request onto the ALU line and collects the 3-word reply.
// Strictly one op in flight; req_valid is ignored while busy. Define ALU_ARB_PARITY_CHK_EN to flag reply parity errors.
module alu_op_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_ARGS = 9,
  parameter int TIMEOUT  = 64,
  localparam int AW      = $clog2(MAX_ARGS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*8-1:0]          req_cmd,
  input  logic [NREQ*AW-1:0]         req_nargs,
  input  logic [NREQ*MAX_ARGS*8-1:0] req_args,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [7:0]                 rsp_status,
  output logic [15:0]                rsp_data,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       alu_sin,
  input  logic                       alu_sout
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef ALU_ARB_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RSP, RECV, DONE} state_t;

  state_t          state;
  logic [GW-1:0]   last;
  logic [GW-1:0]   owner;
  logic [7:0]      cmd_q;
  logic [AW-1:0]   nargs_q;
  logic [7:0]      args_q [MAX_ARGS];
  logic [3:0]      bit_cnt;
  logic [AW-1:0]   word_idx;
  logic [TW-1:0]   tmr;
  logic [9:0]      rx_sh;
  logic [1:0]      rx_idx;
  logic            err_q;
  logic [7:0]      sts_q;
  logic [7:0]      hi_q;
  logic [7:0]      lo_q;

  logic            gnt_any;
  logic [GW-1:0]   gnt_idx;
  logic [GW-1:0]   cand;
  logic [AW-1:0]   gnt_nargs;
  logic            gnt_bad;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] own_oh;
  logic [9:0]      cur_word;

  function automatic logic [9:0] mk_word(input logic t, input logic [7:0] p);
    return {t, p, ^{t, p}};
  endfunction

  // Frame position 0 is the start bit, 1..10 the word MSB first, 11 the stop bit.
  function automatic logic tx_bit(input logic [9:0] w, input logic [3:0] pos);
    if (pos == 4'd0)       return 1'b0;
    else if (pos >= 4'd11) return 1'b1;
    else                   return w[4'd10 - pos];
  endfunction

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GW'((int'(last) + i) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_nargs = req_nargs[gnt_idx*AW +: AW];
    gnt_bad   = (gnt_nargs == '0) || (gnt_nargs > AW'(MAX_ARGS));
    gnt_oh    = NREQ'(1) << gnt_idx;
    own_oh    = NREQ'(1) << owner;
    if (word_idx < nargs_q) cur_word = mk_word(1'b0, args_q[word_idx]);
    else                    cur_word = mk_word(1'b1, cmd_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= GW'(NREQ - 1);
      owner      <= '0;
      cmd_q      <= '0;
      nargs_q    <= '0;
      for (int k = 0; k < MAX_ARGS; k++) args_q[k] <= '0;
      bit_cnt    <= '0;
      word_idx   <= '0;
      tmr        <= '0;
      rx_sh      <= '0;
      rx_idx     <= '0;
      err_q      <= 1'b0;
      sts_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_status <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      alu_sin    <= 1'b1;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner     <= gnt_idx;
            last      <= gnt_idx;
            req_ready <= gnt_oh;
            busy      <= 1'b1;
            cmd_q     <= req_cmd[gnt_idx*8 +: 8];
            nargs_q   <= gnt_nargs;
            for (int k = 0; k < MAX_ARGS; k++)
              args_q[k] <= req_args[(int'(gnt_idx) * MAX_ARGS + k) * 8 +: 8];
            bit_cnt   <= '0;
            word_idx  <= '0;
            sts_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            // Bad lengths are still accepted so the requester gets an error reply.
            if (gnt_bad) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q   <= 1'b0;
              alu_sin <= 1'b0;
              state   <= SEND;
            end
          end
        end
        SEND: begin
          if (bit_cnt == 4'd11) begin
            if (word_idx == nargs_q) begin
              alu_sin <= 1'b1;
              tmr     <= '0;
              rx_idx  <= '0;
              state   <= WAIT_RSP;
            end else begin
              word_idx <= word_idx + 1'b1;
              bit_cnt  <= '0;
              alu_sin  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            alu_sin <= tx_bit(cur_word, bit_cnt + 4'd1);
          end
        end
        WAIT_RSP: begin
          if (!alu_sout) begin
            bit_cnt <= '0;
            state   <= RECV;
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            sts_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            state <= DONE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RECV: begin
          if (bit_cnt == 4'd10) begin
            // Status word carries type 1, the two data words type 0.
            if (!alu_sout || (rx_sh[9] != (rx_idx == 2'd0))) err_q <= 1'b1;
            if (PAR_CHK && (rx_sh[0] != ^rx_sh[9:1])) err_q <= 1'b1;
            case (rx_idx)
              2'd0:    sts_q <= rx_sh[8:1];
              2'd1:    hi_q  <= rx_sh[8:1];
              default: lo_q  <= rx_sh[8:1];
            endcase
            if (rx_idx == 2'd2) begin
              state <= DONE;
            end else begin
              rx_idx <= rx_idx + 2'd1;
              tmr    <= '0;
              state  <= WAIT_RSP;
            end
          end else begin
            rx_sh   <= {rx_sh[8:0], alu_sout};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        DONE: begin
          rsp_valid  <= own_oh;
          rsp_status <= sts_q;
          rsp_data   <= {hi_q, lo_q};
          rsp_err    <= err_q;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
